// File: rtl/mod_fifo_pkg.sv
// mod_fifo_pkg: shared constants and helpers for the FWFT FIFO stage.
// Default width/depth and the occupancy-counter width function.
package mod_fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  function automatic int fifo_level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mod_fifo_ram.sv
// mod_fifo_ram: DEPTH x WIDTH storage, sync write port, async read port.
// Ports: clk, we_i, waddr_i, wdata_i, raddr_i, rdata_o. No reset.
module mod_fifo_ram
  import mod_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mod_fifo_stage.sv
// mod_fifo_stage: first-word-fall-through FIFO, valid/ready on both sides.
// Ports: clk, rst_n, flush, in_*/out_* handshakes, data_in/out, level, afull.
module mod_fifo_stage
  import mod_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AFULL = 3,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = fifo_level_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [LW-1:0]    level,
  output logic             afull
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          push, pop, full;

  assign full      = (count_q == LW'(DEPTH));
  // in_ready is a function of registered state and flush only
  assign in_ready  = !full && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  // a pop during flush is discarded
  assign pop       = out_valid && out_ready && !flush;
  assign level     = count_q;
  assign afull     = (count_q >= LW'(AFULL));

  mod_fifo_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (push),
    .waddr_i(wr_ptr_q),
    .wdata_i(data_in),
    .raddr_i(rd_ptr_q),
    .rdata_o(data_out)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + LW'(1);
        2'b01:   count_d = count_q - LW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_mod_fifo_stage.sv
// tb_mod_fifo_stage: table vectors plus queue scoreboard for mod_fifo_stage.
// Hand-written sequences cover streaming, flush and mid-burst reset.
module tb_mod_fifo_stage;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int LW = $clog2(D + 1);

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  data_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  data_out;
  logic [LW-1:0] level;
  logic          afull;

  mod_fifo_stage #(
    .WIDTH(W),
    .DEPTH(D),
    .AFULL(AF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .level    (level),
    .afull    (afull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  logic [W-1:0] mq[$];
  bit m_rdy, m_vld;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // scoreboard: compare pre-edge outputs against the queue model
  task automatic check_model();
    m_vld = (mq.size() != 0);
    m_rdy = (mq.size() != D) && !flush;
    chk("sb_in_ready", int'(in_ready), int'(m_rdy));
    chk("sb_out_valid", int'(out_valid), int'(m_vld));
    chk("sb_level", int'(level), mq.size());
    chk("sb_afull", int'(afull), int'(mq.size() >= AF));
    if (m_vld) chk("sb_data_out", int'(data_out), int'(mq[0]));
  endtask

  task automatic update_model();
    if (flush) mq.delete();
    else begin
      if (m_vld && out_ready) void'(mq.pop_front());
      if (in_valid && m_rdy) mq.push_back(data_in);
    end
  endtask

  task automatic cyc(input logic f, input logic iv,
                     input logic [W-1:0] d, input logic ordy);
    flush = f; in_valid = iv; data_in = d; out_ready = ordy;
    @(negedge clk);
    check_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic       chk_d;
    logic [7:0] exp_d;
    int         exp_lvl;
    logic       exp_af;
    logic       exp_rdy;
    logic       exp_vld;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1, 8'h11, 0, 0, 8'h00, 1, 0, 1, 1};
    tbl[1]  = '{1, 8'h22, 0, 0, 8'h00, 2, 0, 1, 1};
    tbl[2]  = '{1, 8'h33, 0, 0, 8'h00, 3, 1, 1, 1};
    tbl[3]  = '{1, 8'h44, 0, 0, 8'h00, 4, 1, 0, 1};
    tbl[4]  = '{1, 8'h55, 0, 0, 8'h00, 4, 1, 0, 1};
    tbl[5]  = '{1, 8'h55, 1, 1, 8'h11, 3, 1, 1, 1};
    tbl[6]  = '{1, 8'h55, 0, 1, 8'h22, 4, 1, 0, 1};
    tbl[7]  = '{0, 8'h00, 1, 1, 8'h22, 3, 1, 1, 1};
    tbl[8]  = '{0, 8'h00, 1, 1, 8'h33, 2, 0, 1, 1};
    tbl[9]  = '{0, 8'h00, 1, 1, 8'h44, 1, 0, 1, 1};
    tbl[10] = '{0, 8'h00, 1, 1, 8'h55, 0, 0, 1, 0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    data_in = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_afull", int'(afull), 0);

    // fill, hold-off, pop-from-full, drain
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].chk_d) begin
        flush = 0; in_valid = tbl[i].iv;
        data_in = tbl[i].din; out_ready = tbl[i].ordy;
        #1;
        chk($sformatf("tbl%0d_dout", i), int'(data_out),
            int'(tbl[i].exp_d));
      end
      cyc(1'b0, tbl[i].iv, tbl[i].din, tbl[i].ordy);
      chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].exp_lvl);
      chk($sformatf("tbl%0d_afull", i), int'(afull), int'(tbl[i].exp_af));
      chk($sformatf("tbl%0d_in_ready", i), int'(in_ready),
          int'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_out_valid", i), int'(out_valid),
          int'(tbl[i].exp_vld));
    end

    // streaming with wrap-around: level holds at 1
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        in_valid = 1; data_in = W'(i); out_ready = 1; #1;
        chk($sformatf("stream%0d_dout", i), int'(data_out), i - 1);
      end
      cyc(1'b0, 1'b1, W'(i), 1'b1);
      chk($sformatf("stream%0d_level", i), int'(level), 1);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("stream_drained", int'(out_valid), 0);

    // flush with level 3 and a push attempt in the flush cycle
    cyc(1'b0, 1'b1, 8'hC1, 1'b0);
    cyc(1'b0, 1'b1, 8'hC2, 1'b0);
    cyc(1'b0, 1'b1, 8'hC3, 1'b0);
    chk("pre_flush_level", int'(level), 3);
    cyc(1'b1, 1'b1, 8'hEE, 1'b1);
    chk("flush_level", int'(level), 0);
    chk("flush_out_valid", int'(out_valid), 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_flush_empty", int'(out_valid), 0);
    cyc(1'b0, 1'b1, 8'h77, 1'b0);
    chk("post_flush_dout", int'(data_out), 8'h77);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // asynchronous reset mid-burst
    cyc(1'b0, 1'b1, 8'hB1, 1'b0);
    cyc(1'b0, 1'b1, 8'hB2, 1'b0);
    chk("pre_rst_level", int'(level), 2);
    in_valid = 0; out_ready = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", int'(out_valid), 0);
    chk("async_rst_level", int'(level), 0);
    chk("async_rst_afull", int'(afull), 0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", int'(in_ready), 1);
    cyc(1'b0, 1'b1, 8'hA5, 1'b0);
    chk("rel_dout", int'(data_out), 8'hA5);
    chk("rel_level", int'(level), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
